// File: rtl/k_sort_stream_pkg.sv
// Shared types, FSM encodings and the ordering predicate for the streaming top-K selector.
package misc_pkg;

  localparam int KEY_W = 32;
  localparam int IDX_W = 16;
  // Keys are extended to this width before comparison, so WIDTH must stay below it.
  localparam int CMP_W = 128;

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  typedef struct packed {
    logic             valid;
    logic [KEY_W-1:0] key;
    logic [IDX_W-1:0] index;
  } entry_t;

  // True when a ranks strictly ahead of b: smaller for mode=1, larger for mode=0.
  function automatic logic better(input logic [CMP_W-1:0] a, input logic [CMP_W-1:0] b,
                                  input logic mode, input logic signed_cmp);
    logic lt;
    logic gt;
    if (signed_cmp) begin
      lt = $signed(a) < $signed(b);
      gt = $signed(a) > $signed(b);
    end else begin
      lt = a < b;
      gt = a > b;
    end
    return mode ? lt : gt;
  endfunction

endpackage

// File: rtl/k_sort_stream_cell.sv
// One slot of the sorted shift-register array; cells are chained from rank 0 downwards.
module k_sort_cell
  import misc_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int IDXW   = 16,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             accept,
  input  logic             mode,
  input  logic [WIDTH-1:0] new_key,
  input  logic [IDXW-1:0]  new_index,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_key,
  input  logic [IDXW-1:0]  up_index,
  input  logic             up_ins,
  output logic             valid,
  output logic [WIDTH-1:0] key,
  output logic [IDXW-1:0]  index,
  output logic             ins
);

  logic [CMP_W-1:0] new_ext;
  logic [CMP_W-1:0] key_ext;

  always_comb begin
    if (SIGNED != 0) begin
      new_ext = CMP_W'($signed(new_key));
      key_ext = CMP_W'($signed(key));
    end else begin
      new_ext = CMP_W'(new_key);
      key_ext = CMP_W'(key);
    end
  end

  // Strict comparison: an equal key does not claim this slot, keeping ties in arrival order.
  assign ins = up_ins | ~valid | better(new_ext, key_ext, mode, SIGNED != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      key   <= '0;
      index <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      key   <= '0;
      index <= '0;
    end else if (accept) begin
      if (up_ins) begin
        valid <= up_valid;
        key   <= up_key;
        index <= up_index;
      end else if (ins) begin
        valid <= 1'b1;
        key   <= new_key;
        index <= new_index;
      end
    end
  end

endmodule

// File: rtl/k_sort_stream.sv
// Streaming top-K selector: inserts one pair per cycle, then drains the K best in rank order.
module k_sort_stream
  import misc_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int IDXW   = 16,
  parameter int K      = 20,
  parameter int SIGNED = 0,
  localparam int CW    = $clog2(K + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             asce,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_key,
  input  logic [IDXW-1:0]  in_index,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_key,
  output logic [IDXW-1:0]  out_index,
  output logic [CW-1:0]    out_rank,
  output logic             out_last,
  output logic [CW-1:0]    count
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and a presented output holds until it is taken.

  logic [0:0]    state;
  logic          mode;
  logic          mode_pending;
  logic [CW-1:0] p;

  logic             slot_valid [K];
  logic [WIDTH-1:0] slot_key   [K];
  logic [IDXW-1:0]  slot_index [K];
  logic             slot_ins   [K];

  logic accept;
  logic eff_mode;
  logic out_fire;
  logic flush;

  assign in_ready  = (state == ST_FILL) && !clear;
  assign accept    = in_valid && in_ready;
  assign eff_mode  = mode_pending ? asce : mode;
  assign out_valid = (state == ST_DRAIN) && (p < count);
  assign out_last  = out_valid && (p == count - 1'b1);
  assign out_fire  = out_valid && out_ready && !clear;
  assign flush     = clear || (out_fire && out_last);

  for (genvar i = 0; i < K; i++) begin : g_cell
    logic             up_valid;
    logic [WIDTH-1:0] up_key;
    logic [IDXW-1:0]  up_index;
    logic             up_ins;
    if (i == 0) begin : g_head
      assign up_valid = 1'b0;
      assign up_key   = '0;
      assign up_index = '0;
      assign up_ins   = 1'b0;
    end else begin : g_link
      assign up_valid = slot_valid[i-1];
      assign up_key   = slot_key[i-1];
      assign up_index = slot_index[i-1];
      assign up_ins   = slot_ins[i-1];
    end
    k_sort_cell #(.WIDTH(WIDTH), .IDXW(IDXW), .SIGNED(SIGNED)) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .accept   (accept),
      .mode     (eff_mode),
      .new_key  (in_key),
      .new_index(in_index),
      .up_valid (up_valid),
      .up_key   (up_key),
      .up_index (up_index),
      .up_ins   (up_ins),
      .valid    (slot_valid[i]),
      .key      (slot_key[i]),
      .index    (slot_index[i]),
      .ins      (slot_ins[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_FILL;
      mode         <= 1'b1;
      mode_pending <= 1'b1;
      count        <= '0;
      p            <= '0;
    end else if (clear) begin
      state        <= ST_FILL;
      mode_pending <= 1'b1;
      count        <= '0;
      p            <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (accept) begin
            mode_pending <= 1'b0;
            if (mode_pending) mode <= asce;
            // While not full the last slot is empty, so its flag is always set.
            if (slot_ins[K-1] && (count != CW'(K))) count <= count + 1'b1;
            if (in_last) begin
              state <= ST_DRAIN;
              p     <= '0;
            end
          end
        end
        default: begin
          if (out_fire) begin
            if (out_last) begin
              state        <= ST_FILL;
              mode_pending <= 1'b1;
              count        <= '0;
              p            <= '0;
            end else begin
              p <= p + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    out_key   = '0;
    out_index = '0;
    out_rank  = '0;
    if (out_valid) begin
      out_rank = p;
      for (int i = 0; i < K; i++) begin
        if (p == CW'(i)) begin
          out_key   = slot_key[i];
          out_index = slot_index[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_k_sort_stream.sv
// Directed bench for k_sort_stream with K=4: an unsigned and a signed instance share all inputs.
module tb_k_sort_stream;

  localparam int WIDTH = 32;
  localparam int IDXW  = 16;
  localparam int K     = 4;
  localparam int CW    = $clog2(K + 1);

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             asce;
  logic             in_valid;
  logic [WIDTH-1:0] in_key;
  logic [IDXW-1:0]  in_index;
  logic             in_last;
  logic             out_ready;

  logic             u_in_ready, u_out_valid, u_out_last;
  logic [WIDTH-1:0] u_out_key;
  logic [IDXW-1:0]  u_out_index;
  logic [CW-1:0]    u_out_rank, u_count;

  logic             s_in_ready, s_out_valid, s_out_last;
  logic [WIDTH-1:0] s_out_key;
  logic [IDXW-1:0]  s_out_index;
  logic [CW-1:0]    s_out_rank, s_count;

  int vectors;
  int miscompares;

  logic [WIDTH+IDXW-1:0] exp_q[$];
  logic [WIDTH+IDXW-1:0] exp_s_q[$];

  k_sort_stream #(.WIDTH(WIDTH), .IDXW(IDXW), .K(K), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .clear(clear), .asce(asce),
    .in_valid(in_valid), .in_ready(u_in_ready), .in_key(in_key), .in_index(in_index),
    .in_last(in_last), .out_valid(u_out_valid), .out_ready(out_ready),
    .out_key(u_out_key), .out_index(u_out_index), .out_rank(u_out_rank),
    .out_last(u_out_last), .count(u_count)
  );

  k_sort_stream #(.WIDTH(WIDTH), .IDXW(IDXW), .K(K), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .clear(clear), .asce(asce),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_key(in_key), .in_index(in_index),
    .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_key(s_out_key), .out_index(s_out_index), .out_rank(s_out_rank),
    .out_last(s_out_last), .count(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] k, input logic [IDXW-1:0] x);
    exp_q.push_back({k, x});
    exp_s_q.push_back({k, x});
  endtask

  task automatic send(input logic [WIDTH-1:0] k, input logic [IDXW-1:0] x,
                      input logic last, input logic a);
    @(negedge clk);
    in_valid = 1'b1;
    in_key   = k;
    in_index = x;
    in_last  = last;
    asce     = a;
    chk("in_ready_fill", u_in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_out(input int r, input int n,
                           input logic [WIDTH+IDXW-1:0] e, input logic [WIDTH+IDXW-1:0] es);
    chk("u_out_valid", u_out_valid, 1);
    chk("u_out_key",   u_out_key,   e[WIDTH+IDXW-1:IDXW]);
    chk("u_out_index", u_out_index, e[IDXW-1:0]);
    chk("u_out_rank",  u_out_rank,  r);
    chk("u_out_last",  u_out_last,  (r == n - 1));
    chk("u_count",     u_count,     n);
    chk("u_in_ready_drain", u_in_ready, 0);
    chk("s_out_valid", s_out_valid, 1);
    chk("s_out_key",   s_out_key,   es[WIDTH+IDXW-1:IDXW]);
    chk("s_out_index", s_out_index, es[IDXW-1:0]);
    chk("s_out_last",  s_out_last,  (r == n - 1));
  endtask

  task automatic drain(input int n, input int stall_rank);
    logic [WIDTH+IDXW-1:0] e;
    logic [WIDTH+IDXW-1:0] es;
    for (int r = 0; r < n; r++) begin
      @(negedge clk);
      e  = exp_q.pop_front();
      es = exp_s_q.pop_front();
      check_out(r, n, e, es);
      if (r == stall_rank) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check_out(r, n, e, es);
        end
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    chk("done_out_valid", u_out_valid, 0);
    chk("done_in_ready",  u_in_ready,  1);
    chk("done_count",     u_count,     0);
    chk("done_s_valid",   s_out_valid, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    asce      = 1'b1;
    in_valid  = 1'b0;
    in_key    = '0;
    in_index  = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  u_in_ready,  1);
    chk("rst_out_valid", u_out_valid, 0);
    chk("rst_out_key",   u_out_key,   0);
    chk("rst_out_index", u_out_index, 0);
    chk("rst_out_rank",  u_out_rank,  0);
    chk("rst_out_last",  u_out_last,  0);
    chk("rst_count",     u_count,     0);
    chk("rst_s_ready",   s_in_ready,  1);
    rst_n = 1'b1;

    // Ascending: 9 falls off once four better keys are held.
    send(7, 0, 0, 1); send(3, 1, 0, 1); send(9, 2, 0, 1); send(1, 3, 0, 1); send(5, 4, 1, 1);
    push_exp(1, 3); push_exp(3, 1); push_exp(5, 4); push_exp(7, 0);
    drain(4, -1);

    // Descending; asce flips after the first accept and must be ignored.
    send(7, 0, 0, 0); send(3, 1, 0, 1); send(9, 2, 0, 1); send(1, 3, 0, 1); send(5, 4, 1, 1);
    push_exp(9, 2); push_exp(7, 0); push_exp(5, 4); push_exp(3, 1);
    drain(4, -1);

    // Ties keep arrival order.
    send(5, 0, 0, 1); send(5, 1, 0, 1); send(5, 2, 1, 1);
    push_exp(5, 0); push_exp(5, 1); push_exp(5, 2);
    drain(3, -1);

    // Backpressure at rank 1.
    send(4, 0, 0, 1); send(2, 1, 0, 1); send(8, 2, 0, 1); send(6, 3, 1, 1);
    push_exp(2, 1); push_exp(4, 0); push_exp(6, 3); push_exp(8, 2);
    drain(4, 1);

    // Same bit patterns ordered signed versus unsigned.
    send(32'hFFFF_FFFE, 0, 0, 1); send(32'd3, 1, 0, 1); send(32'hFFFF_FFF9, 2, 1, 1);
    exp_q.push_back({32'd3, 16'd1});
    exp_q.push_back({32'hFFFF_FFF9, 16'd2});
    exp_q.push_back({32'hFFFF_FFFE, 16'd0});
    exp_s_q.push_back({32'hFFFF_FFF9, 16'd2});
    exp_s_q.push_back({32'hFFFF_FFFE, 16'd0});
    exp_s_q.push_back({32'd3, 16'd1});
    drain(3, -1);

    // clear mid-drain with a competing input.
    send(10, 0, 0, 1); send(20, 1, 1, 1);
    @(negedge clk);
    chk("clr_rank0_key", u_out_key, 10);
    @(negedge clk);
    chk("clr_rank1_key",  u_out_key,  20);
    chk("clr_rank1_rank", u_out_rank, 1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_key   = 99;
    in_index = 9;
    in_last  = 1'b1;
    chk("clr_in_ready", u_in_ready, 0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    chk("clr_out_valid", u_out_valid, 0);
    chk("clr_count",     u_count,     0);
    chk("clr_in_ready_after", u_in_ready, 1);
    send(50, 7, 1, 1);
    push_exp(50, 7);
    drain(1, -1);

    // Asynchronous reset mid-FILL.
    send(11, 0, 0, 1); send(12, 1, 0, 1);
    @(negedge clk);
    chk("pre_arst_count", u_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count",     u_count,     0);
    chk("arst_in_ready",  u_in_ready,  1);
    chk("arst_out_valid", u_out_valid, 0);
    chk("arst_out_key",   u_out_key,   0);
    @(negedge clk);
    rst_n = 1'b1;
    send(3, 5, 1, 0);
    push_exp(3, 5);
    drain(1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
